// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 16-bit pipeline.
// Owns the PC and the IF/ID register and runs a req/ack handshake to the
// shared instruction SRAM. Holds IF/ID on decode stalls, inserts bubbles
// when memory is slow or the MEM stage owns the SRAM.
//
// Optional feature macro: IF_BRANCH_SQUASH_EN
//   undefined (default): branches have one delay slot; the in-flight or
//                        next-completed fetch is delivered, the target is
//                        fetched after it.
//   defined            : no delay slot; an accepted branch discards the
//                        in-flight/buffered word and refetches at the target.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_i,
  input  logic        stall_req_int_i,
  input  logic        branch_flag_i,
  input  logic [15:0] branch_addr_i,
  input  logic        mem_busy_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] pc_o,
  output logic [15:0] inst_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] redirect_addr_r;
  logic        redirect_pend_r;
  logic [15:0] buf_inst_r;
  logic [15:0] buf_pc_r;
  logic [15:0] ifid_pc_r;
  logic [15:0] ifid_inst_r;
  logic        ifid_valid_r;

  logic        stall_s;
  logic        br_take_s;
  logic        squash_s;
  logic        req_s;
  logic        ack_s;
  logic [15:0] pc_inc_s;
  logic [15:0] next_pc_s;

  // Decode-side controls: combined stall, accepted branch, squash request.
  always_comb begin
    stall_s   = stall_req_i | stall_req_int_i;
    br_take_s = branch_flag_i & ~stall_s;
`ifdef IF_BRANCH_SQUASH_EN
    squash_s  = br_take_s;
`else
    squash_s  = 1'b0;
`endif
  end

  // Memory handshake: request only in S_REQ while the SRAM is free; an ack
  // counts only while our request is actually asserted. A squash withdraws
  // the request so the reissue can go to the target next cycle.
  always_comb begin
    req_s    = (state_r == S_REQ) & ~mem_busy_i & ~squash_s;
    ack_s    = req_s & imem_ack_i;
    pc_inc_s = pc_r + 16'd1;
  end

  // Next fetch address: same-cycle branch first, then a pending redirect,
  // otherwise sequential (wraps naturally at 16 bits).
  always_comb begin
    if (br_take_s) begin
      next_pc_s = branch_addr_i;
    end else if (redirect_pend_r) begin
      next_pc_s = redirect_addr_r;
    end else begin
      next_pc_s = pc_inc_s;
    end
  end

  // Pending-redirect tracker: a branch accepted without a completing fetch
  // is remembered until the delay-slot fetch acks; newer branches overwrite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pend_r <= 1'b0;
      redirect_addr_r <= 16'h0000;
    end else if (squash_s) begin
      redirect_pend_r <= 1'b0;
    end else if (ack_s) begin
      redirect_pend_r <= 1'b0;
    end else if (br_take_s) begin
      redirect_pend_r <= 1'b1;
      redirect_addr_r <= branch_addr_i;
    end else begin
      redirect_pend_r <= redirect_pend_r;
    end
  end

  // Fetch FSM with PC, fetch buffer and IF/ID register. IF/ID is only
  // written when no stall is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      buf_inst_r   <= NOP_INST;
      buf_pc_r     <= 16'h0000;
      ifid_pc_r    <= 16'h0000;
      ifid_inst_r  <= NOP_INST;
      ifid_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // First request goes out the cycle after reset release.
          state_r <= S_REQ;
          if (squash_s) begin
            pc_r <= branch_addr_i;
          end
        end
        S_REQ: begin
          if (squash_s) begin
            // Drop whatever was in flight and restart at the target.
            pc_r         <= branch_addr_i;
            ifid_inst_r  <= NOP_INST;
            ifid_valid_r <= 1'b0;
          end else if (ack_s) begin
            pc_r <= next_pc_s;
            if (stall_s) begin
              // Decode cannot take it yet: park the word and stop requesting.
              buf_inst_r <= imem_rdata_i;
              buf_pc_r   <= pc_inc_s;
              state_r    <= S_HOLD;
            end else begin
              ifid_inst_r  <= imem_rdata_i;
              ifid_pc_r    <= pc_inc_s;
              ifid_valid_r <= 1'b1;
            end
          end else if (!stall_s) begin
            // Busy SRAM or slow memory: feed decode a bubble.
            ifid_inst_r  <= NOP_INST;
            ifid_valid_r <= 1'b0;
          end else begin
            ifid_valid_r <= ifid_valid_r;
          end
        end
        S_HOLD: begin
          if (squash_s) begin
            pc_r         <= branch_addr_i;
            ifid_inst_r  <= NOP_INST;
            ifid_valid_r <= 1'b0;
            state_r      <= S_REQ;
          end else if (!stall_s) begin
            ifid_inst_r  <= buf_inst_r;
            ifid_pc_r    <= buf_pc_r;
            ifid_valid_r <= 1'b1;
            state_r      <= S_REQ;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          ifid_inst_r  <= NOP_INST;
          ifid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: address is pc while requesting (stable until ack), zero otherwise.
  always_comb begin
    imem_req_o  = req_s;
    imem_addr_o = (state_r == S_REQ) ? pc_r : 16'h0000;
    pc_o        = ifid_pc_r;
    inst_o      = ifid_inst_r;
    valid_o     = ifid_valid_r;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: randomized decode/memory stimulus,
// scoreboard of fetched words, address-stream reference model.
module tb_if_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req_i = 1'b0;
  logic        stall_req_int_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [15:0] branch_addr_i = 16'h0000;
  logic        mem_busy_i = 1'b0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [15:0] imem_rdata_i = 16'h0000;
  logic [15:0] pc_o;
  logic [15:0] inst_o;
  logic        valid_o;

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .stall_req_i(stall_req_i), .stall_req_int_i(stall_req_int_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .mem_busy_i(mem_busy_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } word_t;

  // Words fetched from memory but not yet seen in IF/ID, oldest first.
  word_t sb_q[$];

  // Address model: address of the next fetch, plus a redirect target that
  // applies to the fetch after the next completed one.
  logic [15:0] exp_addr = RESET_PC;
  logic        tgt_valid = 1'b0;
  logic [15:0] tgt = 16'h0000;

  int stall_pct = 0;
  int busy_pct  = 0;
  int br_pct    = 0;
  int ack_pct   = 100;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_req", {15'd0, imem_req_o}, 16'd0);
    chk("rst_addr", imem_addr_o, 16'h0000);
    chk("rst_pc_o", pc_o, 16'h0000);
    chk("rst_inst", inst_o, NOP);
    chk("rst_valid", {15'd0, valid_o}, 16'd0);
  endtask

  function automatic logic [15:0] pick_target();
    logic [15:0] r;
    case ($urandom_range(0, 3))
      0: r = 16'h0040;
      1: r = 16'hFFFE;
      2: r = 16'hFFFF;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  // One cycle of random stimulus, applied just after the rising edge.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    stall_req_i     = ($urandom_range(0, 99) < stall_pct);
    stall_req_int_i = ($urandom_range(0, 99) < stall_pct / 2);
    branch_flag_i   = ($urandom_range(0, 99) < br_pct);
    branch_addr_i   = pick_target();
    mem_busy_i      = ($urandom_range(0, 99) < busy_pct);
    imem_ack_i      = ($urandom_range(0, 99) < ack_pct);
    imem_rdata_i    = imem_addr_o ^ 16'h1000;
  endtask

  // Monitor: on the falling edge, check IF/ID against the previous edge's
  // inputs, then account for this cycle's fetch/branch in the model.
  initial begin : monitor
    logic        prev_live = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_pc = 16'h0000;
    logic [15:0] prev_inst = NOP;
    logic        prev_valid = 1'b0;
    logic        stall_now;
    logic        accept;
    logic        fire;
    logic        exp_v;
    word_t       w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb_q.delete();
        exp_addr  = RESET_PC;
        tgt_valid = 1'b0;
        prev_live = 1'b0;
      end else begin
        if (prev_live) begin
          if (prev_stall) begin
            chk("stall_hold_pc", pc_o, prev_pc);
            chk("stall_hold_inst", inst_o, prev_inst);
            chk("stall_hold_valid", {15'd0, valid_o}, {15'd0, prev_valid});
          end else begin
            exp_v = (sb_q.size() > 0);
            chk("valid", {15'd0, valid_o}, {15'd0, exp_v});
            if (exp_v && valid_o) begin
              w = sb_q.pop_front();
              chk("deliver_pc", pc_o, w.pc);
              chk("deliver_inst", inst_o, w.inst);
            end else if (!exp_v) begin
              chk("bubble_inst", inst_o, NOP);
            end
          end
        end
        stall_now = stall_req_i | stall_req_int_i;
        accept    = branch_flag_i & ~stall_now;
        fire      = imem_req_o & imem_ack_i;
        if (mem_busy_i) chk("busy_no_req", {15'd0, imem_req_o}, 16'd0);
        if (sb_q.size() > 0) chk("held_no_req", {15'd0, imem_req_o}, 16'd0);
`ifdef IF_BRANCH_SQUASH_EN
        if (accept) begin
          chk("squash_no_req", {15'd0, imem_req_o}, 16'd0);
          sb_q.delete();
          exp_addr = branch_addr_i;
        end else if (fire) begin
          chk("fetch_addr", imem_addr_o, exp_addr);
          sb_q.push_back('{pc: exp_addr + 16'd1, inst: exp_addr ^ 16'h1000});
          exp_addr = exp_addr + 16'd1;
          fires++;
        end
`else
        if (accept) begin
          tgt_valid = 1'b1;
          tgt       = branch_addr_i;
        end
        if (fire) begin
          chk("fetch_addr", imem_addr_o, exp_addr);
          sb_q.push_back('{pc: exp_addr + 16'd1, inst: exp_addr ^ 16'h1000});
          exp_addr  = tgt_valid ? tgt : exp_addr + 16'd1;
          tgt_valid = 1'b0;
          fires++;
        end
`endif
        prev_stall = stall_now;
        prev_live  = 1'b1;
      end
      prev_pc    = pc_o;
      prev_inst  = inst_o;
      prev_valid = valid_o;
    end
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    @(posedge clk);
    #1 rst = 1'b1;

    // Zero-wait memory, straight-line fetch.
    ack_pct = 100;
    repeat (12) drive_cycle();
    // Branch near the top of memory to exercise the 16-bit wrap.
    @(posedge clk);
    #1;
    branch_flag_i = 1'b1;
    branch_addr_i = 16'hFFFE;
    imem_rdata_i  = imem_addr_o ^ 16'h1000;
    repeat (10) drive_cycle();

    // Stalls only, then slow memory, then everything together.
    stall_pct = 35; br_pct = 0;  busy_pct = 0;  ack_pct = 100;
    repeat (150) drive_cycle();
    stall_pct = 0;  br_pct = 10; busy_pct = 25; ack_pct = 40;
    repeat (300) drive_cycle();
    stall_pct = 30; br_pct = 15; busy_pct = 20; ack_pct = 60;
    repeat (1500) drive_cycle();

    // Reset while a request is outstanding and a redirect is pending.
    @(posedge clk);
    #1;
    stall_req_i = 1'b0; stall_req_int_i = 1'b0; mem_busy_i = 1'b0;
    imem_ack_i = 1'b0; branch_flag_i = 1'b1; branch_addr_i = 16'h0040;
    @(posedge clk);
    #1;
    branch_flag_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_values();
    @(posedge clk);
    #1 rst = 1'b1;
    stall_pct = 0; br_pct = 0; busy_pct = 0; ack_pct = 100;
    repeat (20) drive_cycle();

    @(posedge clk);
    #1;
    branch_flag_i = 1'b0; imem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    chk("fetch_progress", {15'd0, (fires >= 300)}, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
